// File: rtl/bert_pkg.sv
// Shared definitions for the BERT pattern generator and error checker.
package bert_pkg;

  // Generator / checker sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Mode encoding; the error checker decodes the same values
  localparam logic MODE_PRBS7  = 1'b0;
  localparam logic MODE_PRBS15 = 1'b1;

  // LFSR storage is sized for the longest polynomial
  localparam int LFSR_W = 15;

  // Feedback taps (bit positions in the shift register)
  localparam int PRBS7_TAP_A  = 6;
  localparam int PRBS7_TAP_B  = 5;
  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;

  // Default non-zero seeds
  localparam logic [6:0]  PRBS7_SEED_DEF  = 7'h7F;
  localparam logic [14:0] PRBS15_SEED_DEF = 15'h7FFF;

endpackage

// File: rtl/prbs_byte_step.sv
// Combinational 8-step LFSR advance; yields the next state and the byte
// formed by the eight generated bits (first bit in bit 7).
module prbs_byte_step
  import bert_pkg::*;
(
  input  logic              mode_i,
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [7:0]        byte_o
);

  logic [LFSR_W-1:0] s;
  logic              b;

  // Unrolled eight single-bit steps of the selected polynomial
  always_comb begin
    s      = state_i;
    b      = 1'b0;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      if (mode_i == MODE_PRBS15) begin
        b = s[PRBS15_TAP_A] ^ s[PRBS15_TAP_B];
        s = {s[13:0], b};
      end else begin
        b = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
        s = {8'h00, s[5:0], b};
      end
      byte_o[7-i] = b;
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_tx_gen.sv
// Byte-wide PRBS-7/PRBS-15 transmit generator with valid/ready output
// and single-byte XOR error injection.
module prbs_tx_gen
  import bert_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter logic [6:0]  SEED7  = PRBS7_SEED_DEF,
  parameter logic [14:0] SEED15 = PRBS15_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              inject_req,
  input  logic [DATA_W-1:0] inject_mask,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       byte_count,
  output logic [7:0]        inj_count,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                pend_q, pend_d;
  logic [15:0]         bcnt_q, bcnt_d;
  logic [7:0]          icnt_q, icnt_d;

  logic [LFSR_W-1:0]   step_state;
  logic [7:0]          step_byte;
  logic                accept, load_byte, inj_new, inj_eff;
  logic [DATA_W-1:0]   inj_mask_eff;

  prbs_byte_step u_step (
    .mode_i  (mode_q),
    .state_i (lfsr_q),
    .state_o (step_state),
    .byte_o  (step_byte)
  );

  assign out_valid  = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign out_data   = data_q;
  assign byte_count = bcnt_q;
  assign inj_count  = icnt_q;

  assign accept    = out_valid & out_ready;
  // A new byte is registered at the end of PRIME and on every accept while
  // still enabled; an accept with en low retires the last byte instead.
  assign load_byte = (state_q == ST_PRIME) | (accept & en);
  assign inj_new   = inject_req & (|inject_mask);
  // A request arriving on the same edge as a byte load corrupts that byte;
  // an already pending mask takes precedence over the new one.
  assign inj_eff      = pend_q | inj_new;
  assign inj_mask_eff = pend_q ? mask_q : inject_mask;

  // Next-state: sequencing, LFSR advance, injection and counters
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    bcnt_d  = bcnt_q;
    icnt_d  = icnt_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_PRIME;
          mode_d  = mode;
          lfsr_d  = (mode == MODE_PRBS15) ? SEED15 : {8'h00, SEED7};
          bcnt_d  = '0;
          icnt_d  = '0;
          pend_d  = 1'b0;
          mask_d  = '0;
        end
      end
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          bcnt_d = bcnt_q + 16'd1;
          if (!en) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Injection XORs only the output byte; the LFSR stays clean so the
    // checker sees a single corrupted byte and resynchronizes at once.
    if (load_byte) begin
      lfsr_d = step_state;
      data_d = step_byte ^ (inj_eff ? inj_mask_eff : '0);
      if (inj_eff) begin
        pend_d = 1'b0;
        icnt_d = (icnt_q == 8'hFF) ? icnt_q : icnt_q + 8'd1;
      end
    end else if ((state_q != ST_IDLE) && inj_new && !pend_q) begin
      pend_d = 1'b1;
      mask_d = inject_mask;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PRBS7;
      lfsr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      pend_q  <= 1'b0;
      bcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      bcnt_q  <= bcnt_d;
      icnt_q  <= icnt_d;
    end
  end

endmodule

// File: tb/tb_prbs_tx_gen.sv
// Self-checking bench for prbs_tx_gen against a bit-serial recurrence model.
module tb_prbs_tx_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic        inject_req;
  logic [7:0]  inject_mask;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] byte_count;
  logic [7:0]  inj_count;
  logic        busy;

  prbs_tx_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .inject_req  (inject_req),
    .inject_mask (inject_mask),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .byte_count  (byte_count),
    .inj_count   (inj_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: sequence x[n] = x[n-L] ^ x[n-L+1], history oldest first
  bit          hist[$];
  logic [7:0]  exp_byte;
  logic [15:0] exp_bcnt;
  logic [7:0]  exp_icnt;
  bit          pend;
  logic [7:0]  pmask;
  logic [6:0]  seed7  = 7'h7F;
  logic [14:0] seed15 = 15'h7FFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_init(input bit m);
    hist.delete();
    if (m) for (int k = 0; k < 15; k++) hist.push_back(seed15[14-k]);
    else   for (int k = 0; k < 7;  k++) hist.push_back(seed7[6-k]);
  endtask

  function automatic logic [7:0] next_byte();
    logic [7:0] r;
    bit nb;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      nb = hist[0] ^ hist[1];
      hist.push_back(nb);
      void'(hist.pop_front());
      r = {r[6:0], nb};
    end
    return r;
  endfunction

  // Start from IDLE; optional ignored request in IDLE, optional request in PRIME
  task automatic start(input bit m, input bit idle_inj, input logic [7:0] prime_mask);
    mode = m; en = 1'b1; out_ready = 1'b0;
    inject_req = idle_inj; inject_mask = 8'hA5;
    model_init(m);
    exp_bcnt = '0; exp_icnt = '0; pend = 1'b0;
    @(negedge clk);
    chk("prime_busy", busy, 1);
    chk("prime_valid", out_valid, 0);
    inject_req = (prime_mask != 0); inject_mask = prime_mask;
    exp_byte = next_byte();
    if (prime_mask != 0) begin exp_byte ^= prime_mask; exp_icnt = 8'd1; end
    @(negedge clk);
    inject_req = 1'b0;
  endtask

  // One RUN cycle: check outputs, drive ready/inject, advance the model
  task automatic cycle(input bit rdy, input bit inj, input logic [7:0] m);
    chk("valid", out_valid, 1);
    chk("data", out_data, exp_byte);
    chk("bcnt", byte_count, exp_bcnt);
    chk("icnt", inj_count, exp_icnt);
    out_ready = rdy; inject_req = inj; inject_mask = m;
    mode = 1'($urandom_range(0, 1));
    if (inj && m != 0 && !pend) begin pend = 1'b1; pmask = m; end
    @(negedge clk);
    inject_req = 1'b0;
    if (rdy) begin
      exp_bcnt++;
      exp_byte = next_byte();
      if (pend) begin
        exp_byte ^= pmask;
        pend = 1'b0;
        if (exp_icnt != 8'hFF) exp_icnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; inject_req = 1'b0;
    inject_mask = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bcnt", byte_count, 0);
    chk("rst_icnt", inj_count, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // PRBS-7 reference bytes and period
    start(1'b0, 1'b1, 8'h00);
    chk("first7", out_data, 8'h02);
    chk("idle_inj_ign", inj_count, 0);
    cycle(1, 0, 0);
    chk("second7", out_data, 8'h0C);
    for (int i = 0; i < 126; i++) cycle(1, 0, 0);
    chk("period7", out_data, 8'h02);

    // Injection mid-stream, pending-hold, zero mask
    cycle(1, 1, 8'h81);
    cycle(1, 0, 0);
    chk("inj_one", inj_count, 1);
    cycle(1, 0, 0);
    cycle(0, 1, 8'h81);
    cycle(0, 1, 8'h3C);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 8'h00);
    cycle(1, 0, 0);
    chk("inj_two", inj_count, 2);

    // Random backpressure with sporadic injection
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 8'($urandom));

    // Stop while stalled: byte held until accepted
    en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stop_valid", out_valid, 1);
      chk("stop_hold", out_data, exp_byte);
      chk("stop_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_bcnt++;
    chk("stop_done_valid", out_valid, 0);
    chk("stop_done_busy", busy, 0);
    chk("stop_bcnt", byte_count, exp_bcnt);
    out_ready = 1'b0;

    // Restart with injection during PRIME, then saturate inj_count
    start(1'b0, 1'b0, 8'h5A);
    chk("prime_inj", out_data, 8'h02 ^ 8'h5A);
    chk("restart_bcnt", byte_count, 0);
    for (int i = 0; i < 320; i++) cycle(1, 1, 8'($urandom_range(1, 255)));
    chk("icnt_sat", inj_count, 8'hFF);

    // Stop with immediate accept
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("stop_imm_valid", out_valid, 0);
    chk("stop_imm_busy", busy, 0);
    out_ready = 1'b0;

    // Asynchronous reset mid-run
    start(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_bcnt", byte_count, 0);
    chk("arst_icnt", inj_count, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    start(1'b0, 1'b0, 8'h00);
    chk("restart_first", out_data, 8'h02);

    // PRBS-15 long run with byte_count wrap
    en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 65536; i++) cycle(1, 0, 0);
    chk("bcnt_wrap", byte_count, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
